// File: rtl/camera_pkg.sv
// Shared types and constants for the camera save-buffer sequencer.
// Holds the default geometry, the FSM state encodings and the output bit indices.
package camera_pkg;

    localparam int unsigned XSIZE_DEF = 160;
    localparam int unsigned YSIZE_DEF = 120;
    localparam int unsigned CW        = 10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_LINE = 2'd1,
        W_PAD  = 2'd2
    } wstate_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_READ = 2'd2
    } rstate_e;

    localparam int unsigned EN_WR   = 1;
    localparam int unsigned EN_RD   = 0;
    localparam int unsigned ERR_OVF = 1;
    localparam int unsigned ERR_LEN = 0;

endpackage

// File: rtl/camera_savectrl_if.sv
// Camera-side and buffer-side signals of the save controller.
// The master modport is the driving environment; the slave modport is the controller.
interface camera_savectrl_if;
    import camera_pkg::*;

    logic              iVsync;
    logic              iHref;
    logic              iValid;
    logic              iGrant;
    logic [1:0]        oEn;
    logic              oPad;
    logic              oReq;
    logic              oValid;
    logic              oLast;
    logic [CW-1:0]     oLine;
    logic              oFrameDone;
    logic [1:0]        oErr;

    modport master (
        output iVsync, iHref, iValid, iGrant,
        input  oEn, oPad, oReq, oValid, oLast, oLine, oFrameDone, oErr
    );

    modport slave (
        input  iVsync, iHref, iValid, iGrant,
        output oEn, oPad, oReq, oValid, oLast, oLine, oFrameDone, oErr
    );

endinterface

// File: rtl/camera_edgemod.sv
// Registers the camera sync levels once and derives single-cycle edge pulses
// by comparing the live level against its registered copy.
module camera_edgemod (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    input  logic href,
    output logic vsync_rise,
    output logic href_rise,
    output logic href_fall
);

    logic vsync_q, vsync_d;
    logic href_q, href_d;

    always_comb begin
        vsync_d = vsync;
        href_d  = href;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
        end else begin
            vsync_q <= vsync_d;
            href_q  <= href_d;
        end
    end

    always_comb begin
        vsync_rise = vsync & ~vsync_q;
        href_rise  = href & ~href_q;
        href_fall  = ~href & href_q;
    end

endmodule

// File: rtl/camera_savectrl.sv
// Save-buffer sequencer: a write FSM that keeps each line exactly XSIZE words
// and a read FSM that bursts a completed line out after a downstream grant.
module camera_savectrl
    import camera_pkg::*;
#(
    parameter int unsigned XSIZE = XSIZE_DEF,
    parameter int unsigned YSIZE = YSIZE_DEF
) (
    input logic              CLOCK,
    input logic              RESET,
    camera_savectrl_if.slave bus
);

    localparam logic [CW-1:0] XS    = CW'(XSIZE);
    localparam logic [CW-1:0] XLAST = CW'(XSIZE - 1);
    localparam logic [CW-1:0] YLAST = CW'(YSIZE - 1);

    logic vsync_rise, href_rise, href_fall;

    camera_edgemod u_edge (
        .clk        (CLOCK),
        .rst        (RESET),
        .vsync      (bus.iVsync),
        .href       (bus.iHref),
        .vsync_rise (vsync_rise),
        .href_rise  (href_rise),
        .href_fall  (href_fall)
    );

    wstate_e       wstate_q, wstate_d;
    rstate_e       rstate_q, rstate_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] rcnt_q, rcnt_d;
    logic [CW-1:0] line_q, line_d;
    logic [1:0]    err_q, err_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          fdone_q, fdone_d;

    logic en_wr, en_rd, pad, line_done, last_rd, len_err, ovf;
    logic pix;

    assign pix = bus.iValid & bus.iHref;

    // Write side: pad short lines, drop words past XSIZE.
    always_comb begin
        wstate_d  = wstate_q;
        wcnt_d    = wcnt_q;
        en_wr     = 1'b0;
        pad       = 1'b0;
        line_done = 1'b0;
        len_err   = 1'b0;
        unique case (wstate_q)
            W_IDLE: begin
                if (href_rise) begin
                    wstate_d = W_LINE;
                    wcnt_d   = '0;
                end else if (pix) begin
                    len_err = 1'b1;
                end
            end
            W_LINE: begin
                if (wcnt_q == XS) begin
                    line_done = 1'b1;
                    wstate_d  = W_IDLE;
                    len_err   = pix;
                end else if (href_fall) begin
                    wstate_d = W_PAD;
                    len_err  = 1'b1;
                end else if (pix) begin
                    en_wr  = 1'b1;
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            W_PAD: begin
                len_err = href_rise;
                if (wcnt_q == XS) begin
                    line_done = 1'b1;
                    wstate_d  = W_IDLE;
                end else begin
                    en_wr  = 1'b1;
                    pad    = 1'b1;
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Read side: request, then an unbroken burst of XSIZE reads.
    always_comb begin
        rstate_d = rstate_q;
        rcnt_d   = rcnt_q;
        en_rd    = 1'b0;
        last_rd  = 1'b0;
        unique case (rstate_q)
            R_IDLE: begin
                if (line_done) rstate_d = R_REQ;
            end
            R_REQ: begin
                if (bus.iGrant) begin
                    rstate_d = R_READ;
                    rcnt_d   = '0;
                end
            end
            R_READ: begin
                en_rd = 1'b1;
                if (rcnt_q == XLAST) begin
                    last_rd  = 1'b1;
                    rcnt_d   = '0;
                    // A line finishing on the final read is queued straight away.
                    rstate_d = line_done ? R_REQ : R_IDLE;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        ovf = (en_wr & ((rstate_q == R_REQ) |
                        ((rstate_q == R_READ) & (wcnt_q > rcnt_q)))) |
              (line_done & (rstate_q != R_IDLE) & ~last_rd);
    end

    always_comb begin
        line_d  = line_q;
        fdone_d = 1'b0;
        err_d   = err_q;
        err_d[ERR_OVF] = err_q[ERR_OVF] | ovf;
        err_d[ERR_LEN] = err_q[ERR_LEN] | len_err;
        valid_d = en_rd;
        last_d  = last_rd;
        if (last_rd) begin
            if (line_q == YLAST) begin
                line_d  = '0;
                fdone_d = 1'b1;
            end else begin
                line_d = line_q + 1'b1;
            end
        end
        if (vsync_rise) begin
            line_d = '0;
            err_d  = '0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            wstate_q <= W_IDLE;
            rstate_q <= R_IDLE;
            wcnt_q   <= '0;
            rcnt_q   <= '0;
            line_q   <= '0;
            err_q    <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            wstate_q <= wstate_d;
            rstate_q <= rstate_d;
            wcnt_q   <= wcnt_d;
            rcnt_q   <= rcnt_d;
            line_q   <= line_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            fdone_q  <= fdone_d;
        end
    end

    always_comb begin
        bus.oEn        = '0;
        bus.oEn[EN_WR] = en_wr;
        bus.oEn[EN_RD] = en_rd;
        bus.oPad       = pad;
        bus.oReq       = (rstate_q == R_REQ);
        bus.oValid     = valid_q;
        bus.oLast      = last_q;
        bus.oLine      = line_q;
        bus.oFrameDone = fdone_q;
        bus.oErr       = err_q;
    end

endmodule
